// File: rtl/led_decoder_arbiter_pkg.sv
// Shared types and constants for the LED decoder arbiter: decoder enable
// codes, LED index width and the arbiter FSM state encoding.
package led_pkg;

    localparam int         LED_IDX_W  = 3;
    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_decoder_arbiter_if.sv
// Requester/decoder bundle between LED requesters and the arbiter.
// The arbiter (slave) drives grant, done, abort, decoder controls and debug state.
interface led_decoder_arbiter_if #(
    parameter int NREQ = 4
);
    import led_pkg::*;

    // Handshake: req[i] is a level held by requester i until it sees done[i]
    // or abort[i]; grant[i] marks ownership, and dropping req[i] while granted
    // releases the decoder early with an abort[i] pulse.
    logic [NREQ-1:0]           req;
    logic [LED_IDX_W*NREQ-1:0] req_idx;
    logic [NREQ-1:0]           grant;
    logic [NREQ-1:0]           done;
    logic [NREQ-1:0]           abort;
    logic [LED_IDX_W-1:0]      dec_switch;
    logic [2:0]                dec_enable;
    logic                      busy;
    arb_state_t                state_dbg;

    modport master (
        output req,
        output req_idx,
        input  grant,
        input  done,
        input  abort,
        input  dec_switch,
        input  dec_enable,
        input  busy,
        input  state_dbg
    );

    modport slave (
        input  req,
        input  req_idx,
        output grant,
        output done,
        output abort,
        output dec_switch,
        output dec_enable,
        output busy,
        output state_dbg
    );

endinterface

// File: rtl/led_decoder_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_valid
);

    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_valid && req[(int'(ptr) + i) % NREQ]) begin
                win_valid                         = 1'b1;
                win_oh[(int'(ptr) + i) % NREQ]    = 1'b1;
                win_idx                           = PTR_W'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/led_decoder_arbiter.sv
// Shares one registered 3-to-8 LED decoder between NREQ requesters: round-robin
// grant, DWELL cycles of ownership, then GAP blanking cycles.
module led_decoder_arbiter #(
    parameter int NREQ  = 4,
    parameter int DWELL = 8,
    parameter int GAP   = 1
) (
    input logic                 clk,
    input logic                 rst,
    led_decoder_arbiter_if.slave bus
);
    import led_pkg::*;

    localparam int PTR_W = $clog2(NREQ);
    // One counter serves both the dwell and blanking phases.
    localparam int CNT_W = $clog2(max_int(DWELL, GAP) + 1);

    arb_state_t           state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     owner;
    logic [CNT_W-1:0]     cnt;
    logic [NREQ-1:0]      grant_q;
    logic [NREQ-1:0]      done_q;
    logic [NREQ-1:0]      abort_q;
    logic [LED_IDX_W-1:0] switch_q;
    logic [2:0]           enable_q;
    logic                 busy_q;

    logic [NREQ-1:0]      win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_valid;
    logic [LED_IDX_W-1:0] win_sw;
    logic                 owner_req;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (bus.req),
        .ptr       (ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_comb begin
        win_sw    = bus.req_idx[LED_IDX_W*int'(win_idx) +: LED_IDX_W];
        owner_req = bus.req[owner];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            switch_q <= '0;
            enable_q <= DEC_EN_OFF;
            busy_q   <= 1'b0;
        end else begin
            done_q  <= '0;
            abort_q <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state    <= OWN;
                        owner    <= win_idx;
                        grant_q  <= win_oh;
                        switch_q <= win_sw;
                        enable_q <= DEC_EN_ON;
                        busy_q   <= 1'b1;
                        cnt      <= CNT_W'(DWELL - 1);
                        ptr      <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PTR_W'(1);
                    end
                end

                OWN: begin
                    // A dropped request wins over a completed dwell on the same edge.
                    if (!owner_req || cnt == '0) begin
                        if (!owner_req) begin
                            abort_q[owner] <= 1'b1;
                        end else begin
                            done_q[owner] <= 1'b1;
                        end
                        grant_q  <= '0;
                        enable_q <= DEC_EN_OFF;
                        if (GAP == 0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= led_pkg::GAP;
                            cnt   <= CNT_W'(GAP - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                led_pkg::GAP: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    grant_q  <= '0;
                    enable_q <= DEC_EN_OFF;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.abort      = abort_q;
    assign bus.dec_switch = switch_q;
    assign bus.dec_enable = enable_q;
    assign bus.busy       = busy_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_led_decoder_arbiter.sv
// Bench for led_decoder_arbiter: directed scenarios push expected grant/done/abort
// events into a queue; a negedge monitor pops and compares each one it observes.
module tb_led_decoder_arbiter;
    import led_pkg::*;

    localparam int P_NREQ  = 4;
    localparam int P_DWELL = 8;
    localparam int P_GAP   = 1;
    localparam int W       = 16;

    localparam logic [1:0] EV_GRANT = 2'd1;
    localparam logic [1:0] EV_DONE  = 2'd2;
    localparam logic [1:0] EV_ABORT = 2'd3;

    logic clk;
    logic rst;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    led_decoder_arbiter_if #(.NREQ(P_NREQ)) bus ();

    led_decoder_arbiter #(
        .NREQ  (P_NREQ),
        .DWELL (P_DWELL),
        .GAP   (P_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered active-low LED decoder driven by the arbiter outputs.
    always @(posedge clk) begin
        if (bus.dec_enable == 3'b100) led <= ~(8'd1 << bus.dec_switch);
        else                          led <= 8'hff;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic [3:0] vec,
                                        input logic [2:0] sw, input logic [2:0] en,
                                        input logic [3:0] len);
        return {kind, vec, sw, en, len};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_idx(input int i, input logic [2:0] v);
        bus.req_idx[3*i +: 3] = v;
    endtask

    task automatic wait_grant(input int i);
        int n = 0;
        while (bus.grant[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant[i] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_grant%0d timeout got=%b expected bit %0d set", i, bus.grant, i);
        end
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (bus.done[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.done[i] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done%0d timeout got=%b expected bit %0d set", i, bus.done, i);
        end
    endtask

    // scoreboard monitor
    logic [3:0] prev_grant = '0;
    int         own_len    = 0;
    int         gap_len    = 0;
    bit         in_gap     = 1'b0;

    task automatic report_event(input logic [W-1:0] got);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event unexpected got=%h expected=none", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL event kind/vec/sw/en/len got=%0d/%b/%0d/%b/%0d expected=%0d/%b/%0d/%b/%0d",
                         got[15:14], got[13:10], got[9:7], got[6:4], got[3:0],
                         exp[15:14], exp[13:10], exp[9:7], exp[6:4], exp[3:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.grant != '0) begin
            if (prev_grant == '0) begin
                own_len = 1;
                report_event(ev(EV_GRANT, bus.grant, bus.dec_switch, bus.dec_enable, 4'd0));
            end else begin
                own_len++;
            end
        end
        if (bus.done != '0) begin
            report_event(ev(EV_DONE, bus.done, bus.dec_switch, bus.dec_enable, 4'(own_len)));
            in_gap  = 1'b1;
            gap_len = 0;
        end
        if (bus.abort != '0) begin
            report_event(ev(EV_ABORT, bus.abort, bus.dec_switch, bus.dec_enable, 4'(own_len)));
            in_gap  = 1'b1;
            gap_len = 0;
        end
        if (in_gap) begin
            if (bus.busy) begin
                gap_len++;
            end else begin
                check("gap_busy_cycles", 32'(gap_len), 32'(P_GAP));
                in_gap = 1'b0;
            end
        end
        prev_grant = bus.grant;
    end

    // stimulus
    initial begin
        rst         = 1'b0;
        bus.req     = 4'b1111;
        bus.req_idx = {3'd4, 3'd7, 3'd2, 3'd1};

        // Reset holds everything idle even with all requests up.
        repeat (3) @(negedge clk);
        check("rst_grant",  32'(bus.grant), 32'h0);
        check("rst_enable", 32'(bus.dec_enable), 32'h0);
        check("rst_busy",   32'(bus.busy), 32'h0);
        check("rst_done",   32'(bus.done), 32'h0);
        check("rst_abort",  32'(bus.abort), 32'h0);
        check("rst_state",  32'(bus.state_dbg), 32'(IDLE));

        // Round robin with every request held.
        exp_q.push_back(ev(EV_GRANT, 4'b0001, 3'd1, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0001, 3'd1, 3'b000, 4'd8));
        exp_q.push_back(ev(EV_GRANT, 4'b0010, 3'd2, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0010, 3'd2, 3'b000, 4'd8));
        exp_q.push_back(ev(EV_GRANT, 4'b0100, 3'd7, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0100, 3'd7, 3'b000, 4'd8));
        exp_q.push_back(ev(EV_GRANT, 4'b1000, 3'd4, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b1000, 3'd4, 3'b000, 4'd8));
        exp_q.push_back(ev(EV_GRANT, 4'b0001, 3'd1, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0001, 3'd1, 3'b000, 4'd8));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_grant", 32'(bus.grant), 32'h1);
        wait_done(0);
        wait_done(1);
        wait_done(2);
        wait_done(3);
        wait_done(0);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Single requester 2 (pointer now 1).
        set_idx(2, 3'd5);
        exp_q.push_back(ev(EV_GRANT, 4'b0100, 3'd5, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0100, 3'd5, 3'b000, 4'd8));
        bus.req = 4'b0100;
        wait_grant(2);
        check("single_state", 32'(bus.state_dbg), 32'(OWN));
        wait_done(2);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Owner index changes after grant; the latched value must hold.
        set_idx(3, 3'd3);
        exp_q.push_back(ev(EV_GRANT, 4'b1000, 3'd3, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b1000, 3'd3, 3'b000, 4'd8));
        bus.req = 4'b1000;
        wait_grant(3);
        set_idx(3, 3'd6);
        repeat (2) @(negedge clk);
        check("idx_hold_switch", 32'(bus.dec_switch), 32'd3);
        wait_done(3);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Requester 1 drops its request 3 cycles into ownership.
        exp_q.push_back(ev(EV_GRANT, 4'b0010, 3'd2, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_ABORT, 4'b0010, 3'd2, 3'b000, 4'd3));
        bus.req = 4'b0010;
        wait_grant(1);
        repeat (2) @(negedge clk);
        bus.req = 4'b0000;
        repeat (4) @(negedge clk);

        // Async reset in the middle of ownership (pointer was 2, now 1).
        set_idx(0, 3'd6);
        exp_q.push_back(ev(EV_GRANT, 4'b0001, 3'd6, 3'b100, 4'd0));
        bus.req = 4'b0001;
        wait_grant(0);
        repeat (2) @(negedge clk);
        check("led_owned", 32'(led), 32'hbf);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_grant",  32'(bus.grant), 32'h0);
        check("arst_enable", 32'(bus.dec_enable), 32'h0);
        check("arst_busy",   32'(bus.busy), 32'h0);
        check("arst_state",  32'(bus.state_dbg), 32'(IDLE));
        @(posedge clk);
        @(negedge clk);
        check("arst_led", 32'(led), 32'hff);
        check("arst_pulses", 32'({bus.done, bus.abort}), 32'h0);
        // Pointer back at 0: requester 0 must win over requester 1.
        exp_q.push_back(ev(EV_GRANT, 4'b0001, 3'd6, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0001, 3'd6, 3'b000, 4'd8));
        exp_q.push_back(ev(EV_GRANT, 4'b0010, 3'd2, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_DONE,  4'b0010, 3'd2, 3'b000, 4'd8));
        bus.req = 4'b0011;
        rst     = 1'b1;
        wait_done(0);
        wait_done(1);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Request dropped exactly at the last dwell cycle: abort, not done.
        set_idx(2, 3'd5);
        exp_q.push_back(ev(EV_GRANT, 4'b0100, 3'd5, 3'b100, 4'd0));
        exp_q.push_back(ev(EV_ABORT, 4'b0100, 3'd5, 3'b000, 4'd8));
        bus.req = 4'b0100;
        wait_grant(2);
        repeat (7) @(negedge clk);
        bus.req = 4'b0000;
        repeat (5) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
